// File: rtl/lp805x_vtimer_sched.sv
// lp805x_vtimer_sched: shares the new timer's overflow tick (ntf) among four
// virtual down-counting channels. Each tick launches a scan that services
// channel 0..3 on consecutive clocks; expiring channels raise a flag and reload.
// Optional feature macro: LP805X_VTIMER_ONESHOT_EN adds VTMOD (0xFD), one-shot
// mode per channel. Without it 0xFD is undecoded and every channel is periodic.
//
// state | meaning
// IDLE  | no scan running, waiting for a tick or a pended tick
// S0    | service channel 0
// S1    | service channel 1
// S2    | service channel 2
// S3    | service channel 3, chain straight into S0 if another tick is waiting

module lp805x_vtimer_sched #(
    parameter int unsigned CH_BITLEN     = 8,
    parameter int unsigned RELOAD_RSTVAL = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       wr,
    input  logic       wr_bit,
    input  logic       rd,
    input  logic [7:0] wr_addr,
    input  logic [7:0] rd_addr,
    input  logic [7:0] data_in,
    input  logic       bit_in,
    output logic [7:0] data_out,
    output logic       bit_out,
    output logic       vtf
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S0   = 3'd1,
        ST_S1   = 3'd2,
        ST_S2   = 3'd3,
        ST_S3   = 3'd4
    } state_e;

    localparam logic [7:0] A_VTFLG = 8'hF8;
    localparam logic [7:0] A_VTEN  = 8'hF9;
    localparam logic [7:0] A_VTSEL = 8'hFA;
    localparam logic [7:0] A_VTRLD = 8'hFB;
    localparam logic [7:0] A_VTCNT = 8'hFC;
`ifdef LP805X_VTIMER_ONESHOT_EN
    localparam logic [7:0] A_VTMOD = 8'hFD;
`endif
    localparam logic [CH_BITLEN-1:0] CNT_RST = CH_BITLEN'(RELOAD_RSTVAL);

    state_e               state_q, state_d;
    logic                 scan_act;
    logic [1:0]           scan_idx;
    logic                 start_scan;
    logic                 pend_q, pend_d;
    logic                 ovr_q, ovr_d, ovr_set;
    logic [3:0]           flag_q, flag_d, flag_hw;
    logic [7:0]           en_q, en_d;
    logic [1:0]           sel_q, sel_d;
    logic [CH_BITLEN-1:0] rld_q [4];
    logic [CH_BITLEN-1:0] rld_d [4];
    logic [CH_BITLEN-1:0] cnt_q [4];
    logic [CH_BITLEN-1:0] cnt_d [4];
    logic [7:0]           rd_data_q, rd_data_d;
    logic                 rd_hit_q, rd_hit_d;
    logic                 wr_byte, we_flg, we_en, we_sel, we_rld, we_flg_bit;
    logic                 unused_rd;
`ifdef LP805X_VTIMER_ONESHOT_EN
    logic [3:0]           mod_q, mod_d, en_os_clr;
    logic                 we_mod;
`endif

    // Reads decode purely on rd_addr; the strobe carries no information here.
    assign unused_rd = rd;

    assign wr_byte    = wr && !wr_bit;
    assign we_flg     = wr_byte && (wr_addr == A_VTFLG);
    assign we_en      = wr_byte && (wr_addr == A_VTEN);
    assign we_sel     = wr_byte && (wr_addr == A_VTSEL);
    assign we_rld     = wr_byte && (wr_addr == A_VTRLD);
    assign we_flg_bit = wr && wr_bit && (wr_addr[7:3] == 5'b11111);
`ifdef LP805X_VTIMER_ONESHOT_EN
    assign we_mod     = wr_byte && (wr_addr == A_VTMOD);
`endif

    // Scan FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Scan FSM next state: a waiting or arriving tick starts (or chains) a scan.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (pend_q || tick) state_d = ST_S0;
            ST_S0:   state_d = ST_S1;
            ST_S1:   state_d = ST_S2;
            ST_S2:   state_d = ST_S3;
            ST_S3:   state_d = (pend_q || tick) ? ST_S0 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Scan FSM outputs: which channel, if any, is serviced this clock.
    always_comb begin
        scan_act = 1'b0;
        scan_idx = 2'd0;
        unique case (state_q)
            ST_S0:   begin scan_act = 1'b1; scan_idx = 2'd0; end
            ST_S1:   begin scan_act = 1'b1; scan_idx = 2'd1; end
            ST_S2:   begin scan_act = 1'b1; scan_idx = 2'd2; end
            ST_S3:   begin scan_act = 1'b1; scan_idx = 2'd3; end
            default: ;
        endcase
    end

    assign start_scan = (state_d == ST_S0);

    // One-deep tick buffer; a tick that finds it full and not draining is lost.
    always_comb begin
        pend_d  = pend_q;
        ovr_set = 1'b0;
        if (start_scan) begin
            pend_d = pend_q && tick;
        end else if (tick) begin
            if (pend_q) ovr_set = 1'b1;
            else        pend_d  = 1'b1;
        end
    end

    // Per-channel service and reload writes; software reload beats the scan.
    always_comb begin
        flag_hw = 4'b0000;
`ifdef LP805X_VTIMER_ONESHOT_EN
        en_os_clr = 4'b0000;
`endif
        for (int k = 0; k < 4; k++) begin
            cnt_d[k] = cnt_q[k];
            rld_d[k] = rld_q[k];
            if (scan_act && (scan_idx == 2'(k)) && en_q[k]) begin
                if (cnt_q[k] != '0) begin
                    cnt_d[k] = cnt_q[k] - CH_BITLEN'(1);
                end else begin
                    flag_hw[k] = 1'b1;
                    cnt_d[k]   = rld_q[k];
`ifdef LP805X_VTIMER_ONESHOT_EN
                    en_os_clr[k] = mod_q[k];
`endif
                end
            end
            if (we_rld && (sel_q == 2'(k))) begin
                rld_d[k] = CH_BITLEN'(data_in);
                cnt_d[k] = CH_BITLEN'(data_in);
            end
        end
    end

    // Flags: software byte/bit write first, a hardware expiry overrides it.
    always_comb begin
        flag_d = flag_q;
        if (we_flg) flag_d = data_in[3:0];
        if (we_flg_bit && !wr_addr[2]) flag_d[wr_addr[1:0]] = bit_in;
        flag_d = flag_d | flag_hw;
    end

    // Enables, selector and sticky overrun.
    always_comb begin
        en_d = we_en ? data_in : en_q;
`ifdef LP805X_VTIMER_ONESHOT_EN
        if (!we_en) en_d[3:0] = en_q[3:0] & ~en_os_clr;
        mod_d = we_mod ? data_in[3:0] : mod_q;
`endif
        sel_d = we_sel ? data_in[1:0] : sel_q;
        ovr_d = ((we_sel && !data_in[7]) ? 1'b0 : ovr_q) | ovr_set;
    end

    // Read decode, registered one clock later onto data_out.
    always_comb begin
        rd_hit_d  = 1'b1;
        rd_data_d = 8'h00;
        unique case (rd_addr)
            A_VTFLG: rd_data_d = {4'b0000, flag_q};
            A_VTEN:  rd_data_d = en_q;
            A_VTSEL: rd_data_d = {ovr_q, 5'b00000, sel_q};
            A_VTRLD: rd_data_d = 8'(rld_q[sel_q]);
            A_VTCNT: rd_data_d = 8'(cnt_q[sel_q]);
`ifdef LP805X_VTIMER_ONESHOT_EN
            A_VTMOD: rd_data_d = {4'b0000, mod_q};
`endif
            default: rd_hit_d = 1'b0;
        endcase
    end

    // Control and SFR registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= 1'b0;
            ovr_q     <= 1'b0;
            flag_q    <= 4'b0000;
            en_q      <= 8'h00;
            sel_q     <= 2'd0;
            rd_data_q <= 8'h00;
            rd_hit_q  <= 1'b0;
`ifdef LP805X_VTIMER_ONESHOT_EN
            mod_q     <= 4'b0000;
`endif
        end else begin
            pend_q    <= pend_d;
            ovr_q     <= ovr_d;
            flag_q    <= flag_d;
            en_q      <= en_d;
            sel_q     <= sel_d;
            rd_data_q <= rd_data_d;
            rd_hit_q  <= rd_hit_d;
`ifdef LP805X_VTIMER_ONESHOT_EN
            mod_q     <= mod_d;
`endif
        end
    end

    // Channel reload and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                rld_q[k] <= CNT_RST;
                cnt_q[k] <= CNT_RST;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                rld_q[k] <= rld_d[k];
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign data_out = rd_hit_q ? rd_data_q : 8'hzz;
    assign bit_out  = 1'bz;
    assign vtf      = |(flag_q & en_q[7:4]);

endmodule

// File: tb/tb_lp805x_vtimer_sched.sv
// Bench for lp805x_vtimer_sched: timeline model (ticks scheduled as scan start
// cycles) compared every cycle, plus directed scenarios with literal results.

module tb_lp805x_vtimer_sched;

    logic       clk, rst_n, tick, wr, wr_bit, rd, bit_in;
    logic [7:0] wr_addr, rd_addr, data_in;
    wire  [7:0] data_out;
    wire        bit_out;
    wire        vtf;

    int n_pass  = 0;
    int n_total = 0;

    lp805x_vtimer_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .wr       (wr),
        .wr_bit   (wr_bit),
        .rd       (rd),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .data_in  (data_in),
        .bit_in   (bit_in),
        .data_out (data_out),
        .bit_out  (bit_out),
        .vtf      (vtf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    int         cyc    = 0;
    int         last_s = -100;
    int         scans[$];
    int         mk, ms;
    logic [3:0] m_flag = '0, n_flag, hw_flag, os_clr;
    logic [7:0] m_en = '0, n_en;
    logic [1:0] m_sel = '0, n_sel;
    logic       m_ovr = 1'b0, n_ovr;
    logic [3:0] m_mod = '0, n_mod;
    logic [7:0] m_rld [4];
    logic [7:0] m_cnt [4];
    logic [7:0] n_rld [4];
    logic [7:0] n_cnt [4];
    logic [7:0] m_rd = '0;
    bit         m_rd_hiz = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flag = '0; m_en = '0; m_sel = '0; m_ovr = 1'b0; m_mod = '0;
            for (int i = 0; i < 4; i++) begin m_rld[i] = '0; m_cnt[i] = '0; end
            m_rd = '0; m_rd_hiz = 1'b1;
            scans.delete();
            last_s = -100;
            cyc++;
        end else begin
            m_rd_hiz = 1'b0;
            m_rd     = '0;
            case (rd_addr)
                8'hF8: m_rd = {4'b0, m_flag};
                8'hF9: m_rd = m_en;
                8'hFA: m_rd = {m_ovr, 5'b0, m_sel};
                8'hFB: m_rd = m_rld[m_sel];
                8'hFC: m_rd = m_cnt[m_sel];
`ifdef LP805X_VTIMER_ONESHOT_EN
                8'hFD: m_rd = {4'b0, m_mod};
`endif
                default: m_rd_hiz = 1'b1;
            endcase

            n_flag = m_flag; n_en = m_en; n_sel = m_sel; n_ovr = m_ovr; n_mod = m_mod;
            for (int i = 0; i < 4; i++) begin n_rld[i] = m_rld[i]; n_cnt[i] = m_cnt[i]; end
            hw_flag = '0;
            os_clr  = '0;

            foreach (scans[i]) begin
                mk = cyc - scans[i];
                if (mk >= 0 && mk <= 3 && m_en[mk]) begin
                    if (m_cnt[mk] != 8'd0) n_cnt[mk] = m_cnt[mk] - 8'd1;
                    else begin
                        hw_flag[mk] = 1'b1;
                        n_cnt[mk]   = m_rld[mk];
                        os_clr[mk]  = m_mod[mk];
                    end
                end
            end

            if (wr && !wr_bit) begin
                case (wr_addr)
                    8'hF8: n_flag = data_in[3:0];
                    8'hF9: n_en = data_in;
                    8'hFA: begin n_sel = data_in[1:0]; if (!data_in[7]) n_ovr = 1'b0; end
                    8'hFB: begin n_rld[m_sel] = data_in; n_cnt[m_sel] = data_in; end
`ifdef LP805X_VTIMER_ONESHOT_EN
                    8'hFD: n_mod = data_in[3:0];
`endif
                    default: ;
                endcase
            end
            if (wr && wr_bit && wr_addr[7:3] == 5'h1F && !wr_addr[2]) n_flag[wr_addr[1:0]] = bit_in;
            n_flag = n_flag | hw_flag;
            if (!(wr && !wr_bit && wr_addr == 8'hF9)) n_en[3:0] = n_en[3:0] & ~os_clr;

            if (tick) begin
                if (last_s > cyc + 1) n_ovr = 1'b1;
                else begin
                    ms = (cyc + 1 > last_s + 4) ? cyc + 1 : last_s + 4;
                    last_s = ms;
                    scans.push_back(ms);
                end
            end
            while (scans.size() > 0 && cyc - scans[0] >= 3) void'(scans.pop_front());

            m_flag = n_flag; m_en = n_en; m_sel = n_sel; m_ovr = n_ovr; m_mod = n_mod;
            for (int i = 0; i < 4; i++) begin m_rld[i] = n_rld[i]; m_cnt[i] = n_cnt[i]; end
            cyc++;
        end
    end

    // Every-cycle compare of vtf and data_out against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            n_total++;
            if (vtf === |(m_flag & m_en[7:4])) n_pass++;
            else $display("FAIL model_vtf cyc=%0d: got %b, expected %b", cyc, vtf, |(m_flag & m_en[7:4]));
            n_total++;
            if (m_rd_hiz) begin
                if (data_out === 8'hzz) n_pass++;
                else $display("FAIL model_rd_hiz cyc=%0d: got %h, expected zz", cyc, data_out);
            end else begin
                if (data_out === m_rd) n_pass++;
                else $display("FAIL model_rd cyc=%0d: got %h, expected %h", cyc, data_out, m_rd);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, got, exp);
    endtask

    task automatic sfr_wr(input logic [7:0] a, input logic [7:0] d);
        wr = 1'b1; wr_bit = 1'b0; wr_addr = a; data_in = d;
        step();
        wr = 1'b0;
    endtask

    task automatic sfr_bit(input logic [7:0] a, input logic b);
        wr = 1'b1; wr_bit = 1'b1; wr_addr = a; bit_in = b;
        step();
        wr = 1'b0; wr_bit = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic ticks_spaced(input int n, input int gap);
        repeat (n) begin
            pulse_tick();
            repeat (gap - 1) step();
        end
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [7:0] exp);
        rd_addr = a;
        step();
        @(negedge clk);
        chk(nm, data_out, exp);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst_n = 1'b0; tick = 1'b0; wr = 1'b0; wr_bit = 1'b0; rd = 1'b0;
        wr_addr = '0; rd_addr = '0; data_in = '0; bit_in = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // reset values
        n_total++;
        if (bit_out === 1'bz) n_pass++;
        else $display("FAIL bit_out_z: got %b, expected z", bit_out);
        rd_chk("rst_vtflg", 8'hF8, 8'h00);
        rd_chk("rst_vten",  8'hF9, 8'h00);
        rd_chk("rst_vtsel", 8'hFA, 8'h00);
        rd_chk("rst_vtcnt", 8'hFC, 8'h00);
        chk("rst_vtf", {7'b0, vtf}, 8'h00);
        rd_addr = 8'h80;
        step();
        @(negedge clk);
        n_total++;
        if (data_out === 8'hzz) n_pass++;
        else $display("FAIL unknown_addr_z: got %h, expected zz", data_out);

        // periodic: channel 2, reload 3, expires on ticks 4 and 8
        sfr_wr(8'hFA, 8'h02);
        sfr_wr(8'hFB, 8'h03);
        sfr_wr(8'hF9, 8'h44);
        ticks_spaced(3, 10);
        pulse_tick();
        step(); step();
        @(negedge clk); chk("per_vtf_t4_early", {7'b0, vtf}, 8'h00);
        step();
        @(negedge clk); chk("per_vtf_t4", {7'b0, vtf}, 8'h01);
        rd_chk("per_cnt_t4", 8'hFC, 8'h03);
        rd_chk("per_flg_t4", 8'hF8, 8'h04);
        sfr_bit(8'hFA, 1'b0);
        rd_chk("per_flg_clr", 8'hF8, 8'h00);
        repeat (6) step();
        ticks_spaced(3, 10);
        pulse_tick();
        step(); step();
        @(negedge clk); chk("per_vtf_t8_early", {7'b0, vtf}, 8'h00);
        step();
        @(negedge clk); chk("per_vtf_t8", {7'b0, vtf}, 8'h01);
        rd_chk("per_cnt_t8", 8'hFC, 8'h03);

        // back-to-back ticks on channel 1 (reload 5)
        sfr_wr(8'hF8, 8'h00);
        sfr_wr(8'hFA, 8'h01);
        sfr_wr(8'hFB, 8'h05);
        sfr_wr(8'hF9, 8'h02);
        tick = 1'b1; step(); tick = 1'b0; step(); tick = 1'b1; step(); tick = 1'b0;
        repeat (10) step();
        rd_chk("b2b_no_ovr", 8'hFA, 8'h01);
        rd_chk("b2b_cnt2", 8'hFC, 8'h03);
        tick = 1'b1; repeat (3) step(); tick = 1'b0;
        repeat (10) step();
        rd_chk("b2b_ovr", 8'hFA, 8'h81);
        rd_chk("b2b_cnt_lost", 8'hFC, 8'h01);
        sfr_wr(8'hFA, 8'h81);
        rd_chk("ovr_w1_keeps", 8'hFA, 8'h81);
        sfr_wr(8'hFA, 8'h01);
        rd_chk("ovr_w0_clears", 8'hFA, 8'h01);

        // collision: HW set of flag[1] vs SW clear in the same cycle
        sfr_wr(8'hFB, 8'h00);
        sfr_wr(8'hF9, 8'h22);
        pulse_tick();
        repeat (5) step();
        rd_chk("col_flag_set", 8'hF8, 8'h02);
        pulse_tick();
        step();
        sfr_bit(8'hF9, 1'b0);
        rd_chk("col_bitclr_loses", 8'hF8, 8'h02);
        chk("col_vtf", {7'b0, vtf}, 8'h01);
        sfr_bit(8'hF9, 1'b0);
        rd_chk("col_bitclr_alone", 8'hF8, 8'h00);
        pulse_tick();
        step();
        sfr_wr(8'hF8, 8'h00);
        rd_chk("col_byteclr_loses", 8'hF8, 8'h02);
        sfr_wr(8'hF8, 8'h00);

        // VTRLD write to channel 0 while it is being scanned
        sfr_wr(8'hFA, 8'h00);
        sfr_wr(8'hFB, 8'h10);
        sfr_wr(8'hF9, 8'h01);
        pulse_tick();
        sfr_wr(8'hFB, 8'h55);
        repeat (5) step();
        rd_chk("rld_sw_wins_cnt", 8'hFC, 8'h55);
        rd_chk("rld_sw_wins_rld", 8'hFB, 8'h55);
        sfr_wr(8'hFB, 8'h00);
        pulse_tick();
        sfr_wr(8'hFB, 8'h20);
        repeat (5) step();
        rd_chk("rld_flag_still_sets", 8'hF8, 8'h01);
        rd_chk("rld_cnt_sw", 8'hFC, 8'h20);

        // disabled channel 3
        sfr_wr(8'hF8, 8'h00);
        sfr_wr(8'hFA, 8'h03);
        sfr_wr(8'hFB, 8'h00);
        ticks_spaced(5, 6);
        rd_chk("dis_cnt3", 8'hFC, 8'h00);
        rd_chk("dis_flag3", 8'hF8, 8'h00);
        sfr_wr(8'hFA, 8'h00);
        rd_chk("dis_ch0_ran", 8'hFC, 8'h1B);

`ifdef LP805X_VTIMER_ONESHOT_EN
        // one-shot channel 0, reload 1
        sfr_wr(8'hF9, 8'h00);
        sfr_wr(8'hF8, 8'h00);
        sfr_wr(8'hFD, 8'h01);
        sfr_wr(8'hFB, 8'h01);
        sfr_wr(8'hF9, 8'h11);
        ticks_spaced(2, 8);
        rd_chk("os_flag", 8'hF8, 8'h01);
        rd_chk("os_en_cleared", 8'hF9, 8'h10);
        sfr_wr(8'hF8, 8'h00);
        ticks_spaced(6, 6);
        rd_chk("os_no_more", 8'hF8, 8'h00);
        rd_chk("os_cnt", 8'hFC, 8'h01);
        sfr_wr(8'hFB, 8'h00);
        sfr_wr(8'hF9, 8'h11);
        pulse_tick();
        sfr_wr(8'hF9, 8'h11);
        repeat (4) step();
        rd_chk("os_sw_en_wins", 8'hF9, 8'h11);
        rd_chk("os_sw_flag", 8'hF8, 8'h01);
        sfr_wr(8'hFD, 8'h00);
`else
        rd_addr = 8'hFD;
        step();
        @(negedge clk);
        n_total++;
        if (data_out === 8'hzz) n_pass++;
        else $display("FAIL vtmod_undecoded: got %h, expected zz", data_out);
        sfr_wr(8'hFD, 8'h5A);
        rd_addr = 8'hFD;
        step();
        @(negedge clk);
        n_total++;
        if (data_out === 8'hzz) n_pass++;
        else $display("FAIL vtmod_wr_ignored: got %h, expected zz", data_out);
`endif

        // reset mid-scan with a tick pended
        sfr_wr(8'hF8, 8'h00);
        sfr_wr(8'hFB, 8'h00);
        sfr_wr(8'hF9, 8'h11);
        tick = 1'b1; step(); step(); tick = 1'b0;
        #3 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_vtf", {7'b0, vtf}, 8'h00);
        step(); step();
        rst_n = 1'b1;
        step();
        rd_chk("rst2_vtflg", 8'hF8, 8'h00);
        rd_chk("rst2_vten",  8'hF9, 8'h00);
        rd_chk("rst2_vtsel", 8'hFA, 8'h00);
        rd_chk("rst2_vtrld", 8'hFB, 8'h00);
        rd_chk("rst2_vtcnt", 8'hFC, 8'h00);
        sfr_wr(8'hF9, 8'h11);
        pulse_tick();
        @(negedge clk); chk("fresh_vtf_c1", {7'b0, vtf}, 8'h00);
        step();
        @(negedge clk); chk("fresh_vtf_c2", {7'b0, vtf}, 8'h01);
        repeat (4) step();
        rd_chk("fresh_no_ovr", 8'hFA, 8'h00);

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lp805x_vtimer_sched.md
Name: lp805x_vtimer_sched

Overview:
- Scheduler that shares the new timer's overflow tick (ntf) among 4 virtual 8-bit down-counting channels.
- On each tick, a scan FSM visits channels 0..3 in order, one per clock. It decrements each enabled channel, raises a flag on expiry, and reloads the channel.
- Sits on the internal SFR bus beside the new timer. Software programs channels through an SFR window; one combined interrupt request goes to the interrupt controller.

Parameters:
- CH_BITLEN, 8, width of each channel's reload and count registers (must be 8 for SFR access).
- RELOAD_RSTVAL, 0, reset value of every reload and count register.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- tick  in  1  one-clock overflow pulse from the new timer (ntf)
- wr  in  1  SFR write strobe
- wr_bit  in  1  bit-write qualifier
- rd  in  1  SFR read strobe (unused; reads decode on rd_addr)
- wr_addr  in  8  SFR write address; bit address when wr_bit=1
- rd_addr  in  8  SFR read address
- data_in  in  8  SFR write data
- bit_in  in  1  SFR bit write data
- data_out  out(tri)  8  driven only for owned addresses, else 8'hzz
- bit_out  out(tri)  1  constant 1'bz
- vtf  out  1  interrupt request = |(VTFLG[3:0] & VTEN[7:4])

Behaviour:
- SFR map:
  - VTFLG 0xF8: bit-addressable (wr_addr[7:3]=5'b11111); [3:0] expiry flags, [7:4] read 0.
  - VTEN 0xF9: [3:0] channel enable, [7:4] channel interrupt enable.
  - VTSEL 0xFA: [1:0] selected channel; [7] overrun, sticky, write-0-to-clear; other bits read 0.
  - VTRLD 0xFB: reload register of the selected channel.
  - VTCNT 0xFC: count of the selected channel, read-only.
- Reset values: VTFLG=0, VTEN=0, VTSEL=0, all reload/count=RELOAD_RSTVAL, FSM=IDLE, pend=0, data_out=z, vtf=0.
- Reads: registered. rd_addr sampled at edge N; data_out valid in cycle N+1. Unknown address → 8'hzz.
- Writing VTRLD loads both reload[sel] and count[sel].
- FSM states: IDLE, S0, S1, S2, S3.
  - IDLE→S0 when pend=1 or tick=1.
  - S0→S1→S2→S3 unconditionally, one clock each.
  - S3→S0 if pend=1 or tick=1, else IDLE.
- pend (1 bit):
  - Set by a tick that is not consumed the same cycle.
  - Cleared on entry to S0.
  - Tick arriving while pend=1 and the FSM is not entering S0 → overrun set, tick lost.
- Channel k in state Sk:
  - enable[k]=0 → no change.
  - count≠0 → count-1.
  - count=0 → flag[k]=1, count=reload[k].
  - Period is reload+1 ticks; reload=0 fires every tick.
- Latency: tick in cycle c updates channel k at the end of cycle c+1+k. vtf rises in cycle c+2+k.
- Simultaneous events:
  - HW flag set and SW clear (byte or bit write) of the same flag in one cycle → set wins.
  - SW write to VTRLD for a channel in its scan state → SW write wins, scan result discarded, flag may still set.
  - Overrun set and SW clear in one cycle → set wins.
- Changing VTSEL during a scan affects only SFR access, never the scan.
- rst_n assertion mid-scan → immediate return to reset values; a pending tick is dropped.

Optional Feature:
- Macro LP805X_VTIMER_ONESHOT_EN.
- Defined:
  - Adds VTMOD at 0xFD; [3:0] one-shot mode per channel.
  - A one-shot channel that expires sets its flag, reloads, and clears enable[k] in the same edge.
  - SW write to VTEN in that same cycle wins over the hardware clear.
- Undefined:
  - 0xFD is not decoded (reads 8'hzz, writes ignored); all channels periodic.

Test Plan:
- Reset: rst_n=0 mid-scan → all SFRs read reset values, vtf=0, next tick begins a fresh scan at S0.
- Periodic: sel=2, VTRLD=3, VTEN=0x44, 8 ticks spaced 10 clks → flag[2] and vtf rise after tick 4 and tick 8 (each 3 clks after tick), VTCNT reads 3 after each expiry.
- Back-to-back: ticks at c and c+2 → second tick pended, S3→S0 directly, no overrun. Ticks at c, c+1, c+2 → overrun=1, one tick lost.
- Collision: bit-clear VTFLG.1 in the same cycle HW sets flag[1] → flag[1]=1. VTRLD write to ch0 during S0 → count[0]=written value.
- Disabled channel: VTEN[3]=0, reload 0, 5 ticks → count[3] unchanged, flag[3]=0.
- One-shot (macro defined): VTMOD=0x01, reload 1, VTEN=0x01 → flag[0] after tick 2, VTEN[0]=0, no further flags over 6 ticks. Macro undefined: read 0xFD → z.
